// File: rtl/sisc_pkg.sv
// Shared types and sizing for the instruction fetch front end.
package sisc_pkg;

    localparam int unsigned PC_W        = 16;
    localparam int unsigned IR_W        = 32;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program counter with a one-entry pending target for branches resolved mid-fetch.
module pc_reg
    import sisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] br_addr,
    input  logic            br_taken,
    input  logic            load,
    input  logic            capture,
    input  logic            flush,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc,
    output logic            changing
);

    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pend;
    logic            pend_valid;
    logic [PC_W-1:0] pc_nxt;

    assign pc_inc = pc + PC_W'(1);
    assign target = br_taken ? br_addr : pc_inc;

    // A direct write on the flush cycle beats the pending target.
    always_comb begin
        pc_nxt = pc;
        if (load)
            pc_nxt = target;
        else if (flush && pend_valid)
            pc_nxt = pend;
    end

    assign changing = (pc_nxt != pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (capture) begin
                pend       <= target;
                pend_valid <= 1'b1;
            end else if (flush) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch control: PC sequencing, memory handshake with timeout, IR capture.
module pc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] br_addr,
    input  logic            br_taken,
    input  logic            pc_write,
    input  logic            fetch_en,
    input  logic            halt,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_data,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc,
    output logic [IR_W-1:0] ir,
    output logic            ir_valid,
    output logic            fetch_err
);

    fetch_state_t state;
    logic [3:0]   wait_cnt;
    logic         halt_seen;
    logic         pc_load;
    logic         pc_capture;
    logic         pc_flush;
    logic         pc_changing;

    assign pc_load    = pc_write && (state == IDLE || state == DONE);
    assign pc_capture = pc_write && (state == REQ);
    assign pc_flush   = (state == DONE);
    assign imem_addr  = pc;

    pc_reg u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .br_addr  (br_addr),
        .br_taken (br_taken),
        .load     (pc_load),
        .capture  (pc_capture),
        .flush    (pc_flush),
        .pc       (pc),
        .pc_inc   (pc_inc),
        .changing (pc_changing)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            halt_seen <= 1'b0;
            imem_req  <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (pc_changing)
                ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    halt_seen <= 1'b0;
                    wait_cnt  <= '0;
                    if (halt) begin
                        state <= HALTED;
                    end else if (fetch_en) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        ir_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (halt)
                        halt_seen <= 1'b1;
                    if (imem_ack) begin
                        ir       <= imem_data;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                        state    <= DONE;
                    end else if (wait_cnt == 4'(TIMEOUT)) begin
                        // Counter reaching TIMEOUT means TIMEOUT+1 cycles without ack.
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= (halt_seen || halt) ? HALTED : IDLE;
                end
                HALTED: begin
                    imem_req <= 1'b0;
                    state    <= HALTED;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: table-driven fetches plus hand-written corner sequences.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] br_addr;
    logic        br_taken;
    logic        pc_write;
    logic        fetch_en;
    logic        halt;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        bt;
        logic [15:0] ba;
        int unsigned delay;
        logic [31:0] data;
        logic [15:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb_q[$];

    pc_fetch #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_addr   (br_addr),
        .br_taken  (br_taken),
        .pc_write  (pc_write),
        .fetch_en  (fetch_en),
        .halt      (halt),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write  = 1'b0;
        br_taken  = 1'b0;
        br_addr   = '0;
        fetch_en  = 1'b0;
        halt      = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
    endtask

    // Pops the oldest expected transaction and compares it with the captured IR.
    task automatic sb_check(input string name);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb_empty: act=0 req=1", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_ir"}, ir, e.data);
            chk({name, "_irv"}, {31'd0, ir_valid}, 32'd1);
        end
    endtask

    task automatic fetch(input vec_t v, input int idx);
        int          hi;
        logic [15:0] inc;
        string       n;
        sb_t         e;
        n = $sformatf("vec%0d", idx);
        pc_write = v.wr;
        br_taken = v.bt;
        br_addr  = v.ba;
        fetch_en = 1'b1;
        step();
        idle_inputs();
        e.addr = v.exp_pc;
        e.data = v.data;
        sb_q.push_back(e);
        inc = v.exp_pc + 16'd1;
        chk({n, "_pc"}, {16'd0, pc}, {16'd0, v.exp_pc});
        chk({n, "_pc_inc"}, {16'd0, pc_inc}, {16'd0, inc});
        chk({n, "_irv_clr"}, {31'd0, ir_valid}, 32'd0);
        hi = 0;
        for (int unsigned i = 0; i <= v.delay; i++) begin
            if (imem_req === 1'b1 && imem_addr === v.exp_pc)
                hi++;
            if (i == v.delay) begin
                imem_ack  = 1'b1;
                imem_data = v.data;
            end
            step();
        end
        idle_inputs();
        chk({n, "_req_cycles"}, hi, v.delay + 1);
        chk({n, "_req_low"}, {31'd0, imem_req}, 32'd0);
        sb_check(n);
        step();
        chk({n, "_pc_after"}, {16'd0, pc}, {16'd0, v.exp_pc});
        chk({n, "_irv_hold"}, {31'd0, ir_valid}, 32'd1);
    endtask

    initial begin
        int hi;
        sb_t e;

        vecs[0] = '{wr: 1'b0, bt: 1'b0, ba: 16'h0000, delay: 2, data: 32'hDEAD0001, exp_pc: 16'h0000};
        vecs[1] = '{wr: 1'b1, bt: 1'b0, ba: 16'h0000, delay: 0, data: 32'h11111111, exp_pc: 16'h0001};
        vecs[2] = '{wr: 1'b1, bt: 1'b1, ba: 16'hFFFE, delay: 1, data: 32'hA5A5A5A5, exp_pc: 16'hFFFE};
        vecs[3] = '{wr: 1'b1, bt: 1'b0, ba: 16'h1234, delay: 3, data: 32'h12345678, exp_pc: 16'hFFFF};
        vecs[4] = '{wr: 1'b1, bt: 1'b0, ba: 16'h0000, delay: 0, data: 32'hCAFEBABE, exp_pc: 16'h0000};
        vecs[5] = '{wr: 1'b1, bt: 1'b1, ba: 16'h0200, delay: 5, data: 32'h0BADF00D, exp_pc: 16'h0200};

        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_pc", {16'd0, pc}, 32'd0);
        chk("rst_pc_inc", {16'd0, pc_inc}, 32'd1);
        chk("rst_ir", ir, 32'd0);
        chk("rst_irv", {31'd0, ir_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);

        for (int i = 0; i < 6; i++)
            fetch(vecs[i], i);

        // Branch resolved during REQ is deferred until DONE.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        pc_write = 1'b1; br_taken = 1'b1; br_addr = 16'h0040;
        e.addr = 16'h0200; e.data = 32'h00C0FFEE;
        sb_q.push_back(e);
        step();
        idle_inputs();
        chk("defer_pc_req1", {16'd0, pc}, 32'h0200);
        step();
        chk("defer_pc_req2", {16'd0, pc}, 32'h0200);
        chk("defer_addr_req2", {16'd0, imem_addr}, 32'h0200);
        imem_ack = 1'b1; imem_data = 32'h00C0FFEE;
        step();
        idle_inputs();
        chk("defer_pc_done", {16'd0, pc}, 32'h0200);
        sb_check("defer");
        step();
        chk("defer_pc_idle", {16'd0, pc}, 32'h0040);
        chk("defer_irv_clr", {31'd0, ir_valid}, 32'd0);

        // Second pending write overwrites the first; write alongside ack is captured.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        pc_write = 1'b1; br_taken = 1'b1; br_addr = 16'h1000;
        step();
        br_addr = 16'h2000; imem_ack = 1'b1; imem_data = 32'h22222222;
        e.addr = 16'h0040; e.data = 32'h22222222;
        sb_q.push_back(e);
        step();
        idle_inputs();
        chk("ovr_pc_done", {16'd0, pc}, 32'h0040);
        sb_check("ovr");
        step();
        chk("ovr_pc_idle", {16'd0, pc}, 32'h2000);

        // Direct write in DONE beats the pending target.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        pc_write = 1'b1; br_taken = 1'b1; br_addr = 16'h1000;
        imem_ack = 1'b1; imem_data = 32'h33333333;
        e.addr = 16'h2000; e.data = 32'h33333333;
        sb_q.push_back(e);
        step();
        imem_ack = 1'b0;
        br_addr = 16'h3000;
        sb_check("prio");
        step();
        idle_inputs();
        chk("prio_pc", {16'd0, pc}, 32'h3000);

        // Halt during REQ finishes the fetch, then stays halted.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0; imem_ack = 1'b1; imem_data = 32'h44444444;
        e.addr = 16'h3000; e.data = 32'h44444444;
        sb_q.push_back(e);
        step();
        idle_inputs();
        sb_check("halt");
        step();
        fetch_en = 1'b1; pc_write = 1'b1; br_taken = 1'b1; br_addr = 16'h5555;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (imem_req !== 1'b0 || pc !== 16'h3000)
                hi++;
        end
        idle_inputs();
        chk("halt_ignored", hi, 0);

        // Reset clears PC; then an asynchronous reset aborts a fetch mid-cycle.
        rst = 1'b1;
        #2;
        chk("rst2_pc", {16'd0, pc}, 32'd0);
        step();
        rst = 1'b0;
        step();
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk("rst2_first_addr", {16'd0, imem_addr}, 32'd0);
        chk("rst2_req", {31'd0, imem_req}, 32'd1);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", {16'd0, pc}, 32'd0);
        chk("async_irv", {31'd0, ir_valid}, 32'd0);
        chk("async_ir", ir, 32'd0);
        step();
        rst = 1'b0;
        step();

        // No ack: request held TIMEOUT+1 cycles, then sticky error and halt.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req !== 1'b1)
                break;
            hi++;
            step();
        end
        chk("to_req_cycles", hi, 16);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        fetch_en = 1'b1;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (imem_req !== 1'b0)
                hi++;
        end
        fetch_en = 1'b0;
        chk("to_fetch_ignored", hi, 0);
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);

        // Halt beats fetch_en in IDLE.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst3_err", {31'd0, fetch_err}, 32'd0);
        halt = 1'b1; fetch_en = 1'b1;
        step();
        halt = 1'b0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b0)
                hi++;
            step();
        end
        idle_inputs();
        chk("idle_halt_wins", hi, 0);

        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 br_addr  input  16  branch target from branch address calculator.
REQ-004 br_taken  input  1  on pc_write, load br_addr (1) or pc_inc (0).
REQ-005 pc_write  input  1  control strobe: advance PC this cycle.
REQ-006 fetch_en  input  1  request fetch of instruction at current PC.
REQ-007 halt  input  1  stop fetching after current fetch completes.
REQ-008 imem_ack  input  1  instruction memory returns data this cycle.
REQ-009 imem_data  input  32  instruction word, valid when imem_ack=1.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  16  fetch address; equals pc.
REQ-012 pc  output  16  current program counter.
REQ-013 pc_inc  output  16  pc+1, combinational, to branch address calculator.
REQ-014 ir  output  32  instruction register.
REQ-015 ir_valid  output  1  ir holds a completed fetch for the current PC.
REQ-016 fetch_err  output  1  sticky: fetch timed out.
REQ-017 parameter TIMEOUT, default 15, max wait cycles for imem_ack.

Function
REQ-018 pc_inc SHALL equal (pc+1) mod 2^16; 16'hFFFF wraps to 16'h0000.
REQ-019 FSM states SHALL be IDLE, REQ, DONE, HALTED.
REQ-020 IDLE: pc_write SHALL load pc with br_taken ? br_addr : pc_inc on that edge.
REQ-021 IDLE: fetch_en=1 and halt=0 -> REQ; halt=1 -> HALTED (halt wins over fetch_en).
REQ-022 IDLE: pc_write and fetch_en in the same cycle -> PC updates and fetch uses the new PC.
REQ-023 REQ: imem_req=1; imem_addr and pc SHALL stay constant until imem_ack.
REQ-024 REQ: imem_ack=1 -> ir<=imem_data, ir_valid<=1, next state DONE.
REQ-025 ir_valid SHALL clear on the edge entering REQ and on any PC change.
REQ-026 REQ: pc_write SHALL NOT change pc; it SHALL latch target (br_taken ? br_addr : pc_inc) into a one-entry pending register.
REQ-027 A second pc_write while pending is valid SHALL overwrite the pending target.
REQ-028 pc_write in the same cycle as imem_ack SHALL be captured as pending.
REQ-029 DONE (1 cycle): pending target SHALL load into pc; pending clears; pc_write in DONE SHALL be applied directly and takes priority over pending.
REQ-030 DONE -> HALTED if halt was seen at any time during REQ/DONE, else IDLE.
REQ-031 REQ: a 4-bit wait counter SHALL count cycles without ack; at TIMEOUT+1 cycles: fetch_err<=1, imem_req<=0, next state HALTED.
REQ-032 imem_ack outside REQ SHALL be ignored.
REQ-033 HALTED SHALL be sticky until rst; pc_write and fetch_en SHALL be ignored there.

Reset
REQ-034 On rst: pc=0, ir=0, ir_valid=0, imem_req=0, fetch_err=0, pending cleared, counter=0, state IDLE.
REQ-035 rst asserted mid-fetch SHALL abort immediately; imem_req falls without waiting for a clock edge.
REQ-036 First fetch after rst deassertion SHALL use address 16'h0000.

Structure
REQ-037 Shared package sisc_pkg SHALL hold the FSM state type, PC_W=16, IR_W=32, and the TIMEOUT default.
REQ-038 Single module; PC register plus pending logic MAY be split into sub-module pc_reg.

Verification
REQ-039 rst, fetch_en, ack after 2 cycles with 32'hDEAD0001 -> imem_addr=0 held 3 cycles; ir=32'hDEAD0001; ir_valid=1.
REQ-040 pc=16'hFFFF, pc_write, br_taken=0 -> pc=16'h0000; pc_inc=16'h0001.
REQ-041 In REQ, pc_write, br_taken=1, br_addr=16'h0040, ack 3 cycles later -> pc stays unchanged until DONE, then 16'h0040.
REQ-042 fetch_en with no ack -> imem_req high 16 cycles, then low; fetch_err=1; state HALTED; later fetch_en ignored.
REQ-043 halt during REQ, ack next cycle -> ir loaded; state HALTED; no further imem_req.
REQ-044 rst pulse mid-REQ -> imem_req=0 asynchronously; pc=0; ir_valid=0.
